// File: rtl/gb_sprite_pkg.sv
// Shared state encoding, slot layout and attribute bit positions for the sprite fetcher.
// Optional macro SPRITE_CGB_PRIO_EN adds a per-slot OAM index for CGB priority.
package gb_sprite_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT0,
    WAIT1,
    RD_LO,
    LAT_LO,
    RD_HI,
    LAT_HI,
    MERGE,
    DONE
  } fetch_state_e;

  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned ATTR_PRIO    = 7;
  localparam int unsigned ATTR_XFLIP   = 5;
  localparam int unsigned ATTR_DMG_PAL = 4;
  localparam int unsigned ATTR_BANK    = 3;
  localparam int unsigned ATTR_CGB_PAL = 0;

  typedef struct packed {
    logic [1:0] color;
    logic [2:0] pal;
    logic       prio;
`ifdef SPRITE_CGB_PRIO_EN
    logic [3:0] idx;
`endif
  } slot_t;

`ifdef SPRITE_CGB_PRIO_EN
  localparam slot_t TRANSPARENT_SLOT = '{color: 2'b00, pal: 3'b000, prio: 1'b0, idx: 4'hF};
`else
  localparam slot_t TRANSPARENT_SLOT = '{color: 2'b00, pal: 3'b000, prio: 1'b0};
`endif

  function automatic logic [2:0] slot_pal(input logic [7:0] attr, input logic cgb);
    return cgb ? attr[ATTR_CGB_PAL +: 3] : {2'b00, attr[ATTR_DMG_PAL]};
  endfunction

endpackage

// File: rtl/sprite_fetcher_if.sv
// Fetch-request handshake and VRAM read bus between the OAM evaluator side and the sprite fetcher.
interface sprite_fetcher_if;
  logic        sprite_fetch;
  logic [10:0] sprite_addr;
  logic [7:0]  sprite_attr;
  logic [3:0]  sprite_index;
  logic        sprite_fetch_done;
  logic        vram_rd;
  logic [12:0] vram_addr;
  logic        vram_bank;
  logic [7:0]  vram_data;

  modport master (
    output sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data,
    input  sprite_fetch_done, vram_rd, vram_addr, vram_bank
  );

  modport slave (
    input  sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data,
    output sprite_fetch_done, vram_rd, vram_addr, vram_bank
  );
endinterface

// File: rtl/sprite_pix_fifo.sv
// 8-slot sprite pixel shift/merge register; slot 0 is the pixel currently presented.
// Optional macro SPRITE_CGB_PRIO_EN enables index-based overwrite in CGB mode.
module sprite_pix_fifo
  import gb_sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       clear,
  input  logic       shift,
  input  logic       merge,
  input  logic       cgb_mode,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic [7:0] attr,
  input  logic [3:0] index,
  output slot_t      head
);

  slot_t      slots_q [FIFO_DEPTH];
  slot_t      slots_d [FIFO_DEPTH];
  slot_t      base    [FIFO_DEPTH];
  logic [2:0] bit_sel;
  logic [1:0] new_color;
  logic       take;

  // Shift is resolved first so merge index i always lands in post-shift slot i.
  always_comb begin
    bit_sel   = '0;
    new_color = '0;
    take      = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
      base[i] = shift ? slots_q[i + 1] : slots_q[i];
    end
    base[FIFO_DEPTH - 1] = shift ? TRANSPARENT_SLOT : slots_q[FIFO_DEPTH - 1];
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      slots_d[i] = base[i];
      bit_sel    = attr[ATTR_XFLIP] ? 3'(i) : 3'(FIFO_DEPTH - 1 - i);
      new_color  = {hi[bit_sel], lo[bit_sel]};
      take       = merge && (new_color != 2'b00) && ((base[i].color == 2'b00)
`ifdef SPRITE_CGB_PRIO_EN
                   || (cgb_mode && (index < base[i].idx))
`endif
                   );
      if (take) begin
        slots_d[i].color = new_color;
        slots_d[i].pal   = slot_pal(attr, cgb_mode);
        slots_d[i].prio  = attr[ATTR_PRIO];
`ifdef SPRITE_CGB_PRIO_EN
        slots_d[i].idx   = index;
`endif
      end
      if (clear) slots_d[i] = TRANSPARENT_SLOT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) slots_q[i] <= TRANSPARENT_SLOT;
    end else if (ce) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) slots_q[i] <= slots_d[i];
    end
  end

  assign head = slots_q[0];

  logic unused_fifo;
`ifdef SPRITE_CGB_PRIO_EN
  assign unused_fifo = ^{attr[6], attr[3]};
`else
  assign unused_fifo = ^{index, attr[6], attr[3]};
`endif

endmodule

// File: rtl/sprite_fetcher.sv
// Sprite tile-row fetcher: two VRAM plane reads, then merge into the sprite pixel FIFO.
// Optional macro SPRITE_CGB_PRIO_EN enables CGB bank/palette/priority handling.
module sprite_fetcher
  import gb_sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              lcd_on,
  input  logic              isGBC,
  input  logic              fetch_hold,
  input  logic              pix_shift,
  sprite_fetcher_if.slave   bus,
  output logic              busy,
  output logic [1:0]        pix_color,
  output logic [2:0]        pix_pal,
  output logic              pix_bgprio
);

  fetch_state_e state_q, state_d;
  logic [7:0]   lo_q, lo_d, hi_q, hi_d;
  logic         cgb_mode;
  slot_t        head;

`ifdef SPRITE_CGB_PRIO_EN
  assign cgb_mode = isGBC;
`else
  assign cgb_mode = 1'b0;
  logic unused_top;
  assign unused_top = isGBC;
`endif

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE:    if (bus.sprite_fetch) state_d = WAIT0;
      WAIT0:   state_d = WAIT1;
      WAIT1:   if (!fetch_hold) state_d = RD_LO;
      RD_LO:   state_d = LAT_LO;
      LAT_LO:  begin state_d = RD_HI; lo_d = bus.vram_data; end
      RD_HI:   state_d = LAT_HI;
      LAT_HI:  begin state_d = MERGE; hi_d = bus.vram_data; end
      MERGE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // LCD off abandons any fetch in flight without a done pulse.
    if (!lcd_on) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign busy                  = (state_q != IDLE);
  assign bus.sprite_fetch_done = (state_q == DONE);
  assign bus.vram_rd           = (state_q == RD_LO) || (state_q == RD_HI);
  assign bus.vram_addr         = bus.vram_rd ? {1'b0, bus.sprite_addr, state_q == RD_HI} : '0;
  assign bus.vram_bank         = bus.vram_rd & cgb_mode & bus.sprite_attr[ATTR_BANK];

  sprite_pix_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .clear    (!lcd_on),
    .shift    (pix_shift),
    .merge    (state_q == MERGE),
    .cgb_mode (cgb_mode),
    .lo       (lo_q),
    .hi       (hi_q),
    .attr     (bus.sprite_attr),
    .index    (bus.sprite_index),
    .head     (head)
  );

  assign pix_color  = head.color;
  assign pix_pal    = head.pal;
  assign pix_bgprio = head.prio;

endmodule

// File: doc/sprite_fetcher.md
SPRITE_FETCHER -- requirements
Module: sprite_fetcher

Interface
REQ-001 clk  in  1  system clock; all state advances on rising edge gated by ce.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce  in  1  pixel-rate clock enable.
REQ-004 lcd_on  in  1  LCD enabled; low acts as a soft clear.
REQ-005 isGBC  in  1  CGB mode select.
REQ-006 sprite_fetch  in  1  fetch request from the OAM evaluator; held until done is seen.
REQ-007 sprite_addr  in  11  tile row address; valid from the 3rd ce of a request onward.
REQ-008 sprite_attr  in  8  OAM attribute byte: [7] BG prio, [6] Y-flip (already applied), [5] X-flip, [4] DMG pal, [3] bank, [2:0] CGB pal.
REQ-009 sprite_index  in  4  evaluator slot 0..9 (ascending OAM order).
REQ-010 fetch_hold  in  1  BG fetcher busy; defers the VRAM reads.
REQ-011 sprite_fetch_done  out  1  one-ce completion pulse.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 vram_rd  out  1  VRAM read strobe.
REQ-014 vram_addr  out  13  {1'b0, sprite_addr, plane}.
REQ-015 vram_bank  out  1  VRAM bank select.
REQ-016 vram_data  in  8  VRAM read data, valid one ce after the address.
REQ-017 pix_shift  in  1  pop slot 0 this ce.
REQ-018 pix_color  out  2  slot-0 colour; 0 = transparent.
REQ-019 pix_pal  out  3  slot-0 palette.
REQ-020 pix_bgprio  out  1  slot-0 BG-priority bit.

Function
REQ-021 States SHALL be IDLE, WAIT0, WAIT1, RD_LO, LAT_LO, RD_HI, LAT_HI, MERGE, DONE; each SHALL last one ce unless stated otherwise.
REQ-022 IDLE SHALL go to WAIT0 when sprite_fetch=1; WAIT0 SHALL go to WAIT1; WAIT1 SHALL stay in WAIT1 while fetch_hold=1, else go to RD_LO.
REQ-023 vram_rd SHALL be 1 in RD_LO (plane 0) and RD_HI (plane 1); vram_data SHALL be latched as lo in LAT_LO and as hi in LAT_HI.
REQ-024 MERGE SHALL capture sprite_attr and sprite_index and merge 8 pixels; pixel i = {hi[b], lo[b]} with b = i if attr[5]=1, else b = 7-i.
REQ-025 A merge SHALL write slot i only if the new colour is nonzero and the slot colour is 0 (DMG rule).
REQ-026 DONE SHALL drive sprite_fetch_done=1 for exactly one ce, then go to IDLE; an IDLE entry with sprite_fetch still 1 SHALL start a new fetch, giving back-to-back latency 9 ce.
REQ-027 With no hold, done SHALL be asserted 8 ce after the request is accepted in IDLE.
REQ-028 pix_shift SHALL shift slots toward slot 0 and fill slot 7 with transparent.
REQ-029 pix_shift coincident with MERGE SHALL shift first; merge index i SHALL then target post-shift slot i.
REQ-030 pix_* outputs SHALL be driven combinationally from slot-0 registers.
REQ-031 lcd_on=0 SHALL force IDLE, clear all slots and hold done=0 from the next ce; a fetch in progress SHALL be abandoned with no done pulse.
REQ-032 Deassertion of sprite_fetch outside IDLE SHALL NOT abort the fetch.

Reset
REQ-033 Reset SHALL set state to IDLE, all slots to colour 0 / pal 0 / prio 0 / index 15, and vram_rd, sprite_fetch_done, busy, vram_addr and vram_bank to 0.
REQ-034 Reset SHALL take effect regardless of ce.

Configuration
REQ-035 With SPRITE_CGB_PRIO_EN defined and isGBC=1:
  - vram_bank = attr[3];
  - pix_pal = attr[2:0];
  - merge also overwrites a nonzero slot when the new colour is nonzero and the new sprite_index is below the slot's stored index.
REQ-036 Without SPRITE_CGB_PRIO_EN, or with isGBC=0:
  - vram_bank = 0;
  - pix_pal = {2'b00, attr[4]};
  - slot index storage SHALL be omitted.

Structure
REQ-037 Shared package gb_sprite_pkg SHALL hold the state encoding, FIFO depth (8), attribute bit positions and transparent-slot constant.
REQ-038 The 8-slot shift/merge register SHALL be sub-module sprite_pix_fifo; the FSM and VRAM interface stay in sprite_fetcher.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
  - Request, sprite_addr=0x155, lo=0xF0, hi=0x0F, attr=0x00 → reads at 0x02AA then 0x02AB; done 8 ce after accept; colours popped = 1,1,1,1,2,2,2,2.
  - Same data, attr=0x20 → popped colours = 2,2,2,2,1,1,1,1.
  - Two overlapping sprites at one X: first lo=0x81, hi=0x00; second lo=0xFF, hi=0xFF → popped = 1,3,3,3,3,3,3,1.
  - fetch_hold high for 5 ce in WAIT1 → done at 13 ce after accept; no vram_rd while held.
  - lcd_on dropped in LAT_LO → no done pulse, slots cleared, busy=0 next ce.
  - SPRITE_CGB_PRIO_EN, isGBC=1, index 3 then index 1 fully opaque → slot-0 pal/colour taken from index 1.
